// File: rtl/dpwm_pkg.sv
// Shared definitions for the sawtooth DPWM generator: default counter width,
// controller state encoding and the phase clamp used when a run starts.
package dpwm_pkg;

   localparam int CNT_W_DEF = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A phase beyond the carrier top would start the counter outside its range,
   // so the start value saturates at the top.
   function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] period);
      return (phase > period) ? period : phase;
   endfunction

endpackage

// File: rtl/dpwm_gen_if.sv
// Control/status bundle of one DPWM cell. The controller side (master) drives
// the run/duty controls, the generator (slave) returns the PWM stream and status.
interface dpwm_gen_if #(
   parameter int CNT_W = dpwm_pkg::CNT_W_DEF
);
   logic             en;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] duty;
   logic             duty_ld;
   logic             dpwm;
   logic             sync;
   logic             duty_ack;
   logic [CNT_W-1:0] cnt;

   modport master (
      output en, period, phase, duty, duty_ld,
      input  dpwm, sync, duty_ack, cnt
   );

   modport slave (
      input  en, period, phase, duty, duty_ld,
      output dpwm, sync, duty_ack, cnt
   );
endinterface

// File: rtl/dpwm_gen.sv
// Counter-based sawtooth DPWM generator. The carrier counts 0..period_act and
// wraps; new period and shadowed duty values are only adopted at the wrap (or
// when a run starts), so the output never glitches mid-period. All outputs are
// registered, one cycle behind the count they were computed from.
module dpwm_gen
   import dpwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   dpwm_gen_if.slave   bus
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] period_act_reg, period_act_next;
   logic [CNT_W-1:0] duty_act_reg, duty_act_next;
   logic [CNT_W-1:0] duty_shd_reg, duty_shd_next;
   logic             pend_reg, pend_next;
   logic             dpwm_reg, dpwm_next;
   logic             sync_reg, sync_next;
   logic             duty_ack_reg, duty_ack_next;
   logic             xfer;

   // Next-state logic: run control, carrier counter, shadow-to-active transfer
   // and the registered compare outputs.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      period_act_next = period_act_reg;
      duty_act_next   = duty_act_reg;
      xfer            = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (bus.en) begin
               state_next      = RUN;
               period_act_next = bus.period;
               cnt_next        = CNT_W'(clamp_phase(32'(bus.phase), 32'(bus.period)));
               xfer            = pend_reg;
            end
         end
         RUN: begin
            if (!bus.en) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == period_act_reg) begin
               cnt_next        = '0;
               period_act_next = bus.period;
               xfer            = pend_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      // The active register always takes the value that was pending before
      // this edge; a strobe arriving on the same edge lands in the shadow and
      // stays pending for the following wrap.
      if (xfer) begin
         duty_act_next = duty_shd_reg;
      end
      duty_shd_next = bus.duty_ld ? bus.duty : duty_shd_reg;
      pend_next     = bus.duty_ld ? 1'b1 : (xfer ? 1'b0 : pend_reg);

      dpwm_next     = (state_reg == RUN) && bus.en && (cnt_reg < duty_act_reg);
      sync_next     = (state_reg == RUN) && (cnt_reg == '0);
      duty_ack_next = xfer;
   end

   // State and datapath registers; reset aborts a run immediately and
   // discards any pending shadow duty.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         period_act_reg <= '0;
         duty_act_reg   <= '0;
         duty_shd_reg   <= '0;
         pend_reg       <= 1'b0;
         dpwm_reg       <= 1'b0;
         sync_reg       <= 1'b0;
         duty_ack_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         period_act_reg <= period_act_next;
         duty_act_reg   <= duty_act_next;
         duty_shd_reg   <= duty_shd_next;
         pend_reg       <= pend_next;
         dpwm_reg       <= dpwm_next;
         sync_reg       <= sync_next;
         duty_ack_reg   <= duty_ack_next;
      end
   end

   assign bus.dpwm     = dpwm_reg;
   assign bus.sync     = sync_reg;
   assign bus.duty_ack = duty_ack_reg;
   assign bus.cnt      = cnt_reg;

endmodule

// File: tb/tb_dpwm_gen.sv
// Scoreboard bench for dpwm_gen: a stimulus process drives one set of inputs
// per cycle and pushes the reference model's prediction; a monitor pops and
// compares after every clock edge.
module tb_dpwm_gen;
   import dpwm_pkg::*;

   localparam int W = CNT_W_DEF;

   typedef struct packed {
      logic         dpwm;
      logic         sync;
      logic         ack;
      logic [W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dpwm_gen_if #(.CNT_W(W)) bus ();

   dpwm_gen #(.CNT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;
   bit   done    = 1'b0;

   // Reference model: the carrier is described by its position inside the
   // current period, the top value and the duty in force for that period.
   bit m_run;
   int m_pos, m_top, m_duty, m_shd;
   bit m_pend;

   task automatic model_step(input bit r, input bit e, input int per, input int ph,
                             input int d, input bit ld, output exp_t x);
      bit xfer;
      x.dpwm = !r && m_run && e && (m_pos < m_duty);
      x.sync = !r && m_run && (m_pos == 0);
      x.ack  = 1'b0;
      if (r) begin
         m_run = 0; m_pos = 0; m_top = 0; m_duty = 0; m_shd = 0; m_pend = 0;
      end else begin
         xfer = 0;
         if (!m_run) begin
            if (e) begin
               m_run = 1;
               m_top = per;
               m_pos = (ph > per) ? per : ph;
               xfer  = m_pend;
            end
         end else if (!e) begin
            m_run = 0;
            m_pos = 0;
         end else if (m_pos == m_top) begin
            m_pos = 0;
            m_top = per;
            xfer  = m_pend;
         end else begin
            m_pos = m_pos + 1;
         end
         if (xfer) m_duty = m_shd;
         x.ack = xfer;
         if (ld) begin
            m_shd  = d;
            m_pend = 1;
         end else if (xfer) begin
            m_pend = 0;
         end
      end
      x.cnt = W'(m_pos);
   endtask

   // Apply one cycle of stimulus on the falling edge and queue its prediction.
   task automatic drive(input bit r, input bit e, input int per, input int ph,
                        input int d, input bit ld);
      exp_t x;
      @(negedge clk);
      rst         = r;
      bus.en      = e;
      bus.period  = W'(per);
      bus.phase   = W'(ph);
      bus.duty    = W'(d);
      bus.duty_ld = ld;
      model_step(r, e, per, ph, d, ld, x);
      exp_q.push_back(x);
      started = 1'b1;
   endtask

   task automatic run_cycles(input int n, input int per);
      for (int i = 0; i < n; i++) drive(0, 1, per, 0, 0, 0);
   endtask

   // Wait (bounded) until the model sits at a given carrier position.
   task automatic run_to_pos(input int pos, input int per);
      for (int i = 0; i < 2000 && m_pos != pos; i++) drive(0, 1, per, 0, 0, 0);
   endtask

   // Monitor: compare every output after each rising edge once stimulus runs.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (started && !done) begin
            a = {bus.dpwm, bus.sync, bus.duty_ack, bus.cnt};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty t=%0t got dpwm=%0b sync=%0b ack=%0b cnt=%0d",
                        $time, a.dpwm, a.sync, a.ack, a.cnt);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL outputs t=%0t got dpwm=%0b sync=%0b ack=%0b cnt=%0d expected dpwm=%0b sync=%0b ack=%0b cnt=%0d",
                           $time, a.dpwm, a.sync, a.ack, a.cnt, e.dpwm, e.sync, e.ack, e.cnt);
               end else begin
                  $display("ok t=%0t dpwm=%0b sync=%0b ack=%0b cnt=%0d",
                           $time, a.dpwm, a.sync, a.ack, a.cnt);
               end
            end
         end
      end
   end

   initial begin
      int per, ph, d;
      bit e, r, ld;
      rst = 1'b1;
      bus.en = 1'b0; bus.period = '0; bus.phase = '0; bus.duty = '0; bus.duty_ld = 1'b0;
      m_run = 0; m_pos = 0; m_top = 0; m_duty = 0; m_shd = 0; m_pend = 0;

      // Basic PWM: reset, load duty 4, run period 9 from phase 0.
      drive(1, 0, 9, 0, 0, 0);
      drive(1, 1, 9, 0, 7, 1);
      drive(0, 0, 9, 0, 4, 1);
      drive(0, 1, 9, 0, 0, 0);
      run_cycles(30, 9);
      // Mid-period duty update at position 2.
      run_to_pos(2, 9);
      drive(0, 1, 9, 0, 7, 1);
      run_cycles(25, 9);
      // Duty 0, then duty above the period (100 %).
      drive(0, 1, 9, 0, 0, 1);
      run_cycles(25, 9);
      drive(0, 1, 9, 0, 10, 1);
      run_cycles(25, 9);
      // Strobe coincident with a wrap while a value is pending.
      run_to_pos(5, 9);
      drive(0, 1, 9, 0, 3, 1);
      run_to_pos(9, 9);
      drive(0, 1, 9, 0, 6, 1);
      run_cycles(25, 9);
      // Period change 9 -> 4 at position 6.
      run_to_pos(6, 9);
      run_cycles(25, 4);
      // Period 0 with duty >= 1, then duty 0.
      run_cycles(6, 0);
      drive(0, 1, 0, 0, 0, 1);
      run_cycles(6, 0);
      // Enable drop at position 3 while high, then restart with phase 5.
      drive(0, 1, 9, 0, 6, 1);
      run_to_pos(0, 9);
      run_to_pos(3, 9);
      drive(0, 0, 9, 0, 0, 0);
      drive(0, 0, 9, 0, 0, 0);
      drive(0, 1, 9, 5, 0, 0);
      run_cycles(20, 9);
      // Phase beyond period clamps; reset during run drops a pending value.
      drive(0, 0, 9, 0, 0, 0);
      drive(0, 1, 9, 15, 0, 0);
      run_cycles(5, 9);
      drive(0, 1, 9, 0, 8, 1);
      drive(1, 1, 9, 0, 0, 0);
      drive(0, 1, 9, 0, 0, 0);
      run_cycles(25, 9);

      // Randomized traffic.
      per = 9;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0)
            per = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << W) - 1)
                                               : $urandom_range(0, 15);
         ph = $urandom_range(0, 20);
         d  = $urandom_range(0, per + 2) & ((1 << W) - 1);
         e  = ($urandom_range(0, 59) != 0);
         r  = ($urandom_range(0, 799) == 0);
         ld = ($urandom_range(0, 7) == 0);
         drive(r, e, per, ph, d, ld);
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      done = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d entries left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
